// File: rtl/pipe_buffer.sv
// Elastic pipeline register: DEPTH-entry circular buffer with valid/ready on both sides,
// synchronous flush and occupancy reporting. Optional zero-latency bypass: PIPE_BUFFER_BYPASS_EN.
module pipe_buffer #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF   = CW'(AF_LEVEL);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             empty, push, pop;

    function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign empty       = (count == '0);
    assign in_ready    = (count != FULL);
    assign almost_full = (count >= AF);
    assign pop         = ~empty & out_ready;

`ifdef PIPE_BUFFER_BYPASS_EN
    logic byp;
    // An empty, unflushed buffer forwards the input straight through; if it is
    // consumed in the same cycle nothing is stored.
    assign byp       = empty & ~flush & in_valid;
    assign out_valid = ~empty | byp;
    assign out_data  = ~empty ? mem[rd_ptr] : (byp ? in_data : '0);
    assign push      = in_valid & in_ready & ~(byp & out_ready);
`else
    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];
    assign push      = in_valid & in_ready;
`endif

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= adv(wr_ptr);
            if (pop)  rd_ptr <= adv(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_buffer.sv
// Bench for pipe_buffer: a DEPTH=4 and a DEPTH=3 instance, scoreboard queues fed at
// accepted pushes and drained by a monitor at every accepted pop.
module tb_pipe_buffer;

    logic clk = 0;
    logic rst_n = 1;
    always #5 clk = ~clk;

    logic       flush4 = 0, in_valid4 = 0, out_ready4 = 0, in_ready4, out_valid4, af4;
    logic [7:0] in_data4 = 0, out_data4;
    logic [2:0] count4;

    logic       flush3 = 0, in_valid3 = 0, out_ready3 = 0, in_ready3, out_valid3, af3;
    logic [7:0] in_data3 = 0, out_data3;
    logic [1:0] count3;

    pipe_buffer #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3)) u4 (
        .clk(clk), .reset(rst_n), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .count(count4), .almost_full(af4));

    pipe_buffer #(.WIDTH(8), .DEPTH(3)) u3 (
        .clk(clk), .reset(rst_n), .flush(flush3), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .count(count3), .almost_full(af3));

    int asserts = 0;
    int fails   = 0;
    logic [7:0] q4[$];
    logic [7:0] q3[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: record accepted pushes, compare every accepted pop against the queue head.
    always @(negedge clk) begin
        if (!rst_n || flush4) q4.delete();
        else begin
            if (in_valid4 && in_ready4) q4.push_back(in_data4);
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) chk("u4 unexpected output", {24'h0, out_data4}, 32'hFFFF_FFFF);
                else chk("u4 out_data", {24'h0, out_data4}, {24'h0, q4.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n || flush3) q3.delete();
        else begin
            if (in_valid3 && in_ready3) q3.push_back(in_data3);
            if (out_valid3 && out_ready3) begin
                if (q3.size() == 0) chk("u3 unexpected output", {24'h0, out_data3}, 32'hFFFF_FFFF);
                else chk("u3 out_data", {24'h0, out_data3}, {24'h0, q3.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

        // Reset asserted mid-cycle, checked before any edge while low.
        #2 rst_n = 0;
        #1;
        chk("reset count4", count4, 0);
        chk("reset in_ready4", in_ready4, 1);
        chk("reset out_valid4", out_valid4, 0);
        chk("reset af4", af4, 0);
        chk("reset out_data4", out_data4, 0);
        chk("reset count3", count3, 0);
        #9 rst_n = 1;
        step();

        // Fill DEPTH=4 with backpressure.
        in_valid4 = 1;
        for (int i = 0; i < 4; i++) begin
            in_data4 = vals[i];
            step();
            chk("fill count", count4, i + 1);
            chk("fill almost_full", af4, (i + 1 >= 3) ? 1 : 0);
        end
        chk("full in_ready", in_ready4, 0);
        chk("full out_data", out_data4, 8'h11);
        in_data4 = 8'h55;
        step();
        chk("full 5th rejected count", count4, 4);
        in_valid4 = 0;

        // Drain.
        out_ready4 = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain head", out_data4, vals[i]);
            step();
        end
        chk("drained out_valid", out_valid4, 0);
        chk("drained out_data", out_data4, 0);
        chk("drained count", count4, 0);
        out_ready4 = 0;

        // DEPTH=3 streaming at constant occupancy across pointer wrap.
        in_valid3 = 1;
        in_data3 = 8'h01; step();
        in_data3 = 8'h02; step();
        chk("stream prefill count", count3, 2);
        out_ready3 = 1;
        for (int v = 3; v <= 10; v++) begin
            in_data3 = 8'(v);
            step();
            chk("stream count", count3, 2);
        end
        in_valid3 = 0;
        step(); step();
        chk("stream drained count", count3, 0);
        out_ready3 = 0;

        // Flush beats simultaneous push and pop.
        in_valid4 = 1;
        in_data4 = 8'h21; step();
        in_data4 = 8'h22; step();
        in_data4 = 8'h23; step();
        chk("preflush count", count4, 3);
        flush4 = 1; in_data4 = 8'h99; out_ready4 = 1;
        #1;
        chk("flush cycle out_valid", out_valid4, 1);
        chk("flush cycle in_ready", in_ready4, 1);
        step();
        flush4 = 0; in_valid4 = 0;
        chk("postflush count", count4, 0);
        chk("postflush out_valid", out_valid4, 0);
        step(); step();
        chk("postflush still empty", out_valid4, 0);
        out_ready4 = 0;

        // Async reset mid-operation, no edge needed.
        in_valid3 = 1;
        in_data3 = 8'h31; step();
        in_data3 = 8'h32; step();
        in_valid3 = 0;
        chk("prereset count3", count3, 2);
        #2 rst_n = 0;
        #1;
        chk("async reset out_valid3", out_valid3, 0);
        chk("async reset count3", count3, 0);
        chk("async reset in_ready3", in_ready3, 1);
        step();
        #3 rst_n = 1;
        step();

        // Bypass / one-cycle latency on empty buffer.
        in_valid4 = 1; in_data4 = 8'hAB; out_ready4 = 1;
        #1;
`ifdef PIPE_BUFFER_BYPASS_EN
        chk("bypass out_valid", out_valid4, 1);
        chk("bypass out_data", out_data4, 8'hAB);
        step();
        in_valid4 = 0;
        chk("bypass count", count4, 0);
        chk("bypass after out_valid", out_valid4, 0);
`else
        chk("nobypass out_valid", out_valid4, 0);
        step();
        in_valid4 = 0;
        chk("nobypass next out_valid", out_valid4, 1);
        chk("nobypass next out_data", out_data4, 8'hAB);
        step();
        chk("nobypass drained count", count4, 0);
`endif
        out_ready4 = 0;
        step();

        chk("scoreboard u4 empty", q4.size(), 0);
        chk("scoreboard u3 empty", q3.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
